fxp_accumulator: RTL
====================

# fxp_accumulator

Parametrised signed fixed-point accumulator that sums a frame of `DEPTH` input samples into one `W`-bit result. It saturates or wraps on overflow, selectable by parameter, and reports a per-frame sticky overflow flag. It sits downstream of the datapath adders and feeds reduction and average stages. Both sides use valid/ready handshakes, so it can sit between stalling producers and consumers.

## Interface
- `W`, 32: sample, accumulator and result width, two's complement.
- `FRAC`, 16: fractional bits. Informational only; binary point is preserved, no rescaling.
- `DEPTH`, 8: samples per frame, ≥1. Need not be a power of two.
- `SAT`, 1: 1 = clamp to most-positive/most-negative on overflow; 0 = wrap modulo 2^W.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clear`  in  1  synchronous frame abort; lower priority than `rst`.
- `in_valid`  in  1  sample valid.
- `in_ready`  out  1  accumulator accepts a sample.
- `in_data`  in  W  signed sample.
- `out_valid`  out  1  frame result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_data`  out  W  signed frame sum.
- `out_overflow`  out  1  an overflow occurred on at least one add in this frame.

## Operation
- States: ACC (collecting samples) and DONE (holding the result).
- Reset values: state=ACC, acc=0, cnt=0, ovf=0, `out_valid`=0, `in_ready`=1, `out_data`=0, `out_overflow`=0.
- ACC:
  - `in_ready`=1.
  - Accept when `in_valid` && `in_ready`.
  - On accept: form W+1-bit sum s = sext(acc) + sext(in_data).
  - Overflow when s[W] != s[W-1].
  - If overflow: SAT=1 gives acc = s[W] ? 1 followed by W-1 zeros : 0 followed by W-1 ones; SAT=0 gives acc = s[W-1:0]. Otherwise acc = s[W-1:0].
  - ovf |= overflow.
- Saturation is not sticky in value: later adds start from the clamped value and may move back in range.
- Counter cnt is $clog2(DEPTH) bits wide (minimum 1). It increments on accept.
- On the accept where cnt == DEPTH-1: cnt returns to 0 and the next state is DONE.
- DONE:
  - `in_ready`=0, `out_valid`=1.
  - `out_data`=acc and `out_overflow`=ovf, held stable until the handshake.
  - On `out_valid` && `out_ready`: acc=0, ovf=0, next state ACC.
- `clear` (either state): acc=0, cnt=0, ovf=0, next state ACC. Any in-flight input or output handshake in that cycle is discarded.
- `rst` during any state gives the full reset state on the next edge. It overrides `clear` and both handshakes.
- DEPTH=1: every accepted sample moves straight to DONE. Result = 0 + sample, so no overflow is possible.

## Timing
- `in_ready` and `out_valid` are registered state decodes. There is no combinational path from `out_ready` to `in_ready`.
- Latency: `out_valid` rises on the edge after the DEPTH-th accept.
- Throughput: at most DEPTH samples per DEPTH+1 cycles. There is one mandatory bubble, the DONE cycle, even when `out_ready` is held at 1.
- `out_data` and `out_overflow` are driven from registers. They are meaningful only while `out_valid`=1; otherwise they hold their last value.
- Backpressure: `out_valid`, `out_data` and `out_overflow` must stay stable while `out_ready`=0.
- `in_valid` deasserted mid-frame: state, acc and cnt hold indefinitely.

## Structure
- Shared package `fxp_pkg` holds:
  - typedef `acc_state_t` {ACC, DONE};
  - functions `fxp_max(W)` and `fxp_min(W)` returning the saturation constants.
- Sub-module `fxp_sat_add #(W, SAT)`: combinational, inputs a, b; outputs result and overflow. It is the generalised saturating adder, reused by other datapath blocks.
- Counter, FSM and registers live in `fxp_accumulator`.

## Test plan
- W=8, DEPTH=4, SAT=1; in 1, 2, 3, 4 with `out_ready`=1 → one cycle after the 4th accept: `out_valid`=1, `out_data`=0x0A, `out_overflow`=0. `in_ready`=0 for exactly that cycle.
- W=8, DEPTH=4, SAT=1; in 0x40 ×4 → `out_data`=0x7F, `out_overflow`=1. Same stimulus with SAT=0 → `out_data`=0x00, `out_overflow`=1.
- W=8, DEPTH=4, SAT=1; in 0x80, 0xFF, 0x05, 0x00 → 0x80+0xFF clamps to 0x80, then +5 gives 0x85 → `out_data`=0x85, `out_overflow`=1. Next frame 1, 1, 1, 1 → 0x04, `out_overflow`=0 (sticky flag cleared between frames).
- Hold `out_ready`=0 for 3 cycles in DONE → `out_valid`/`out_data` stable, `in_ready`=0, `in_valid` pulses ignored. Then `out_ready`=1 → DONE exits, acc=0.
- `clear` after 2 accepts (3, 3), then in 1, 1, 1, 1 → `out_data`=0x04. `clear` asserted in the same cycle as the DONE handshake → result dropped, state ACC.
- `rst` asserted mid-frame and together with `clear` → every output equals its reset value next cycle. The following frame's sum contains no pre-reset samples.

Source files
------------

// File: rtl/fxp_pkg.sv
// Shared definitions for the fixed-point datapath blocks.
//   acc_state_t : accumulator FSM states (ACC collects samples, DONE holds a result)
//   fxp_max(w)  : most-positive w-bit two's complement value, right-aligned in 64 bits
//   fxp_min(w)  : most-negative w-bit two's complement value, sign-extended to 64 bits
// Callers truncate the 64-bit constants to their own width, so w may be 1..64.
package fxp_pkg;

  localparam int FXP_MAX_W = 64;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } acc_state_t;

  function automatic logic [FXP_MAX_W-1:0] fxp_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // The complement of the max pattern has bit w-1 and everything above set,
  // which is exactly the sign-extended most-negative value.
  function automatic logic [FXP_MAX_W-1:0] fxp_min(input int w);
    return ~fxp_max(w);
  endfunction

endpackage

// File: rtl/fxp_sat_add.sv
// Combinational signed adder with optional saturation.
//   W        : operand and result width, two's complement
//   SAT      : 1 = clamp to the representable range on overflow, 0 = wrap modulo 2^W
//   a, b     : signed operands
//   result   : clamped or wrapped sum
//   overflow : the true sum does not fit in W bits
module fxp_sat_add
  import fxp_pkg::*;
#(
  parameter int W   = 32,
  parameter bit SAT = 1'b1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         overflow
);

  localparam logic [W-1:0] MAX_VAL = W'(fxp_max(W));
  localparam logic [W-1:0] MIN_VAL = W'(fxp_min(W));

  logic [W:0] sum_ext;

  // One guard bit is enough for a two-operand add: the guard bit holds the
  // true sign, so a disagreement with bit W-1 means the W-bit view is wrong.
  always_comb begin
    sum_ext  = {a[W-1], a} + {b[W-1], b};
    overflow = sum_ext[W] ^ sum_ext[W-1];
    result   = sum_ext[W-1:0];
    if (SAT && overflow) begin
      result = sum_ext[W] ? MIN_VAL : MAX_VAL;
    end
  end

endmodule

// File: rtl/fxp_accumulator.sv
// Signed fixed-point frame accumulator: sums DEPTH samples into one W-bit
// result, wrapping or saturating per add, with a sticky per-frame overflow flag.
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   clear         : synchronous frame abort (acc, count and flag to zero, back to ACC)
//   in_valid/in_ready/in_data       : sample input handshake
//   out_valid/out_ready/out_data    : frame result handshake
//   out_overflow  : at least one add in the reported frame overflowed
// FRAC only documents the binary point; the sum keeps the input format.
module fxp_accumulator
  import fxp_pkg::*;
#(
  parameter int W     = 32,
  parameter int FRAC  = 16,
  parameter int DEPTH = 8,
  parameter bit SAT   = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_overflow
);

  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

  if (DEPTH < 1) begin : g_bad_depth
    $error("fxp_accumulator: DEPTH must be at least 1");
  end
  if (FRAC < 0 || FRAC >= W) begin : g_bad_frac
    $error("fxp_accumulator: FRAC must lie in 0..W-1");
  end
  if (W < 2 || W > FXP_MAX_W) begin : g_bad_width
    $error("fxp_accumulator: W must lie in 2..64");
  end

  acc_state_t     state;
  acc_state_t     next_state;
  logic [W-1:0]   acc;
  logic [CNT_W-1:0] cnt;
  logic           ovf;

  logic [W-1:0]   sum;
  logic           add_ovf;
  logic           accept;
  logic           out_fire;
  logic           last_sample;

  fxp_sat_add #(
    .W   (W),
    .SAT (SAT)
  ) u_add (
    .a        (acc),
    .b        (in_data),
    .result   (sum),
    .overflow (add_ovf)
  );

  // Handshake qualifiers are decoded from the state register directly so that
  // out_ready never reaches in_ready combinationally.
  assign accept      = in_valid && (state == ACC);
  assign out_fire    = out_ready && (state == DONE);
  assign last_sample = (cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
    end else begin
      state <= next_state;
    end
  end

  // clear overrides both handshakes; otherwise DONE leaves only on the
  // output handshake, which forces the one-cycle bubble between frames.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        if (accept && last_sample) begin
          next_state = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = ACC;
        end
      end
      default: next_state = ACC;
    endcase
    if (clear) begin
      next_state = ACC;
    end
  end

  // The result registers load on the final accept and otherwise hold, so the
  // reported frame stays stable under backpressure and after the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc          <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      out_data     <= '0;
      out_overflow <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= sum;
      ovf <= ovf | add_ovf;
      if (last_sample) begin
        cnt          <= '0;
        out_data     <= sum;
        out_overflow <= ovf | add_ovf;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else if (out_fire) begin
      acc <= '0;
      ovf <= 1'b0;
    end
  end

endmodule
